// File: rtl/idct4_pipe_if.sv
// Handshake bundle for idct4_pipe.
//   in_valid/in_ready/in_data/in_mode : input vector channel (4 coefficients + mode)
//   out_valid/out_ready/out_data/out_sat : output sample channel (4 samples + clip flags)
// master drives vectors in and accepts samples out; slave is the engine.
interface idct4_pipe_if #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4*IN_W-1:0]    in_data;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*OUT_W-1:0]   out_data;
    logic [3:0]           out_sat;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/idct4_pipe.sv
// 4-point inverse transform engine (HEVC DCT-4 / DST-4x4), three register stages:
//   S1 products, S2 4-term sums, S3 round/shift/saturate into the output register.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all stage state
//   bus   - idct4_pipe_if.slave: in_valid/in_ready/in_data/in_mode,
//           out_valid/out_ready/out_data/out_sat
// The whole pipe advances on en = !out_valid || out_ready and freezes otherwise.
module idct4_pipe #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12
) (
    input  logic         clk,
    input  logic         reset,
    idct4_pipe_if.slave  bus
);
    localparam int PW    = IN_W + 8;
    localparam int ACC_W = IN_W + 10;
    localparam int RW    = ACC_W + 1;   // one spare bit so adding the rounding term cannot wrap

    localparam logic signed [RW-1:0] RND     = RW'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 <<< (OUT_W - 1)));

    // Coefficient tables indexed [k][i]: y[i] = sum_k C[k][i] * x[k]
    localparam logic signed [7:0] DCT_C [4][4] = '{
        '{8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{8'sd83,  8'sd36, -8'sd36, -8'sd83},
        '{8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{8'sd36, -8'sd83,  8'sd83, -8'sd36}
    };
    localparam logic signed [7:0] DST_C [4][4] = '{
        '{8'sd29,  8'sd55,  8'sd74,  8'sd84},
        '{8'sd74,  8'sd74,  8'sd0,  -8'sd74},
        '{8'sd84, -8'sd29, -8'sd74,  8'sd55},
        '{8'sd55, -8'sd84,  8'sd74, -8'sd29}
    };

    logic en;

    logic [3:1]             vld_q, vld_d;         // [3] is out_valid
    logic signed [PW-1:0]   prod_q [4][4], prod_d [4][4];   // [i][k]
    logic signed [ACC_W-1:0] sum_q [4], sum_d [4];
    logic [4*OUT_W-1:0]     out_data_q, out_data_d;
    logic [3:0]             out_sat_q, out_sat_d;

    logic signed [IN_W-1:0] x_in [4];
    logic signed [7:0]      coef_sel [4][4];
    logic signed [RW-1:0]   rnd [4];

    // The mode bit only steers coefficient selection, so it is consumed when the
    // S1 products are formed and each product already carries the right sign/weight.
    for (genvar k = 0; k < 4; k++) begin : g_in
        assign x_in[k] = $signed(bus.in_data[k*IN_W +: IN_W]);
        for (genvar i = 0; i < 4; i++) begin : g_coef
            assign coef_sel[k][i] = bus.in_mode ? DST_C[k][i] : DCT_C[k][i];
        end
    end

    // Arithmetic shift floors toward -inf, matching the reference rounding.
    for (genvar i = 0; i < 4; i++) begin : g_rnd
        assign rnd[i] = (RW'(sum_q[i]) + RND) >>> SHIFT;
    end

    assign en            = !vld_q[3] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[3];
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        vld_d      = vld_q;
        prod_d     = prod_q;
        sum_d      = sum_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (en) begin
            vld_d = {vld_q[2:1], bus.in_valid};
            for (int i = 0; i < 4; i++) begin
                // Stage data loads only behind a valid bit so bubbles leave it untouched.
                if (bus.in_valid) begin
                    for (int k = 0; k < 4; k++)
                        prod_d[i][k] = PW'(x_in[k]) * PW'(coef_sel[k][i]);
                end
                if (vld_q[1])
                    sum_d[i] = ACC_W'(prod_q[i][0]) + ACC_W'(prod_q[i][1])
                             + ACC_W'(prod_q[i][2]) + ACC_W'(prod_q[i][3]);
                if (vld_q[2]) begin
                    if (rnd[i] > SAT_MAX) begin
                        out_data_d[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                        out_sat_d[i] = 1'b1;
                    end else if (rnd[i] < SAT_MIN) begin
                        out_data_d[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                        out_sat_d[i] = 1'b1;
                    end else begin
                        out_data_d[i*OUT_W +: OUT_W] = rnd[i][OUT_W-1:0];
                        out_sat_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                sum_q[i] <= '0;
                for (int k = 0; k < 4; k++) prod_q[i][k] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            prod_q     <= prod_d;
            sum_q      <= sum_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end
endmodule
